// File: rtl/datamemory_pkg.sv
// Shared types, constants and the byte-merge helper for datamemory_banked.
package datamemory_pkg;

    localparam int unsigned ByteWidth    = 8;
    localparam int unsigned MaxDataWidth = 512;
    localparam int unsigned MaxBytes     = MaxDataWidth / ByteWidth;

    typedef enum logic {
        StClear,
        StReady
    } clear_state_e;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / ByteWidth;
    endfunction

    // Bytes with byte_en set come from new_word, the rest from old_word.
    function automatic logic [MaxDataWidth-1:0] byte_merge(
        input logic [MaxDataWidth-1:0] old_word,
        input logic [MaxDataWidth-1:0] new_word,
        input logic [MaxBytes-1:0]     byte_en
    );
        logic [MaxDataWidth-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MaxBytes; i++) begin
            if (byte_en[i]) begin
                merged[i*ByteWidth +: ByteWidth] = new_word[i*ByteWidth +: ByteWidth];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/datamemory_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, then parks in StReady.
module datamemory_clear_seq
    import datamemory_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned IdxW  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            busy_o,
    output logic            clr_we_o,
    output logic [IdxW-1:0] clr_addr_o
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

    clear_state_e    state_q, state_d;
    logic [IdxW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    always_comb begin
        busy_o     = (state_q == StClear);
        clr_we_o   = (state_q == StClear);
        clr_addr_o = cnt_q;
    end

endmodule

// File: rtl/datamemory_banked.sv
// 1R/1W data memory with byte enables, write-first forwarding and hardware clear after reset.
// Define DATAMEMORY_OUTREG_EN to add a second output register stage (two-cycle read latency).
module datamemory_banked
    import datamemory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DEPTH      = 16384,
    localparam int unsigned BytesPerWord = bytes_per_word(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   readAddr,
    input  logic                    readEn,
    input  logic [ADDR_WIDTH-1:0]   writeAddr,
    input  logic                    writeEn,
    input  logic [BytesPerWord-1:0] byteEn,
    input  logic [DATA_WIDTH-1:0]   dIn,
    output logic [DATA_WIDTH-1:0]   dOut,
    output logic                    dOutValid,
    output logic                    busy,
    output logic                    addrError
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic            clr_we;
    logic [IdxW-1:0] clr_addr;
    logic [IdxW-1:0] rd_idx, wr_idx;
    logic            rd_in_range, wr_in_range;
    logic            rd_acc, wr_acc, collide;
    logic [DATA_WIDTH-1:0] rd_word, wr_old, wr_merged, rd_fwd;

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    datamemory_clear_seq #(
        .Depth (DEPTH),
        .IdxW  (IdxW)
    ) u_clear_seq (
        .clk_i      (clk),
        .rst_i      (reset),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign rd_idx      = readAddr[IdxW-1:0];
    assign wr_idx      = writeAddr[IdxW-1:0];
    assign rd_in_range = ({1'b0, readAddr} < DepthExt);
    assign wr_in_range = ({1'b0, writeAddr} < DepthExt);
    assign rd_acc      = readEn & ~busy;
    assign wr_acc      = writeEn & ~busy;

    assign rd_word   = mem[rd_idx];
    assign wr_old    = mem[wr_idx];
    assign wr_merged = DATA_WIDTH'(byte_merge(MaxDataWidth'(wr_old), MaxDataWidth'(dIn),
                                              MaxBytes'(byteEn)));

    // Write-first: a same-address read sees the merged word being written this edge.
    assign collide = wr_acc & wr_in_range & (readAddr == writeAddr);
    assign rd_fwd  = collide ? wr_merged : rd_word;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc && wr_in_range) begin
            mem[wr_idx] <= wr_merged;
        end
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = (rd_acc && !rd_in_range) || (wr_acc && !wr_in_range);
        if (rd_acc) begin
            valid_d = 1'b1;
            dout_d  = rd_in_range ? rd_fwd : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef DATAMEMORY_OUTREG_EN
    logic [DATA_WIDTH-1:0] dout2_q;
    logic                  valid2_q;
    logic                  err2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout2_q  <= '0;
            valid2_q <= 1'b0;
            err2_q   <= 1'b0;
        end else begin
            dout2_q  <= dout_q;
            valid2_q <= valid_q;
            err2_q   <= err_q;
        end
    end

    assign dOut      = dout2_q;
    assign dOutValid = valid2_q;
    assign addrError = err2_q;
`else
    assign dOut      = dout_q;
    assign dOutValid = valid_q;
    assign addrError = err_q;
`endif

endmodule

// File: tb/tb_datamemory_banked.sv
// Randomised self-checking bench for datamemory_banked against a word-array reference model.
module tb_datamemory_banked;

    localparam int D  = 16;
    localparam int AW = 5;
`ifdef DATAMEMORY_OUTREG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] readAddr = '0;
    logic          readEn = 1'b0;
    logic [AW-1:0] writeAddr = '0;
    logic          writeEn = 1'b0;
    logic [3:0]    byteEn = '0;
    logic [31:0]   dIn = '0;
    logic [31:0]   dOut;
    logic          dOutValid;
    logic          busy;
    logic          addrError;

    datamemory_banked #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .DEPTH      (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .readAddr  (readAddr),
        .readEn    (readEn),
        .writeAddr (writeAddr),
        .writeEn   (writeEn),
        .byteEn    (byteEn),
        .dIn       (dIn),
        .dOut      (dOut),
        .dOutValid (dOutValid),
        .busy      (busy),
        .addrError (addrError)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: word array, remaining clear cycles, output pipeline.
    logic [31:0] model_mem [D];
    int          clear_left;
    logic [31:0] s1_dout, s2_dout;
    logic        s1_v, s2_v, s1_e, s2_e;
    logic [34:0] exp_vec;  // {valid, error, busy, dout}
    logic [34:0] got;

    always_comb got = {dOutValid, addrError, busy, dOut};

    task automatic model_reset();
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        clear_left = D;
        s1_dout = '0; s2_dout = '0;
        s1_v = 1'b0; s2_v = 1'b0; s1_e = 1'b0; s2_e = 1'b0;
        exp_vec = {1'b0, 1'b0, 1'b1, 32'h0};
    endtask

    // Called at posedge+1; drives one cycle of requests and advances the model.
    task automatic step(input logic re, input logic [AW-1:0] ra, input logic we,
                        input logic [AW-1:0] wa, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] nd, w;
        logic        nv, ne;
        readEn = re; readAddr = ra; writeEn = we; writeAddr = wa; byteEn = be; dIn = d;
        @(posedge clk);
        nd = s1_dout; nv = 1'b0; ne = 1'b0;
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (we && int'(wa) < D) begin
                w = model_mem[wa];
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
                model_mem[wa] = w;
            end
            if (re) begin
                nv = 1'b1;
                nd = (int'(ra) < D) ? model_mem[ra] : 32'h0;
            end
            ne = (re && int'(ra) >= D) || (we && int'(wa) >= D);
        end
        s2_dout = s1_dout; s2_v = s1_v; s2_e = s1_e;
        s1_dout = nd;      s1_v = nv;   s1_e = ne;
        if (Lat == 2) exp_vec = {s2_v, s2_e, clear_left > 0, s2_dout};
        else          exp_vec = {s1_v, s1_e, clear_left > 0, s1_dout};
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 4'h0, 32'h0);
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1; readEn = 1'b0; writeEn = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int cnt;
        #2 reset = 1'b1;
        #1;
        total++;
        if (got !== {1'b0, 1'b0, 1'b1, 32'h0})
            $display("FAIL reset_state: got %h want %h", got, {1'b0, 1'b0, 1'b1, 32'h0});
        else passed++;
        @(posedge clk); #1;
        apply_reset(2);
        cnt = 0;
        // Random requests during the clear must be ignored.
        while (busy === 1'b1 && cnt < 100) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom);
            cnt++;
            total++;
            if (got !== exp_vec) $display("FAIL clear_cycle[%0d]: got %h want %h", cnt, got, exp_vec);
            else passed++;
        end
        total++;
        if (cnt != D) $display("FAIL busy_len: got %0d want %0d", cnt, D);
        else passed++;
        for (int a = 0; a < D + Lat; a++) begin
            if (a < D) step(1'b1, AW'(a), 1'b0, '0, 4'h0, 32'h0);
            else idle();
            total++;
            if (got !== exp_vec) $display("FAIL clear_read[%0d]: got %h want %h", a, got, exp_vec);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        step(1'b0, '0, 1'b1, 5'd0, 4'hF, 32'd5);
        step(1'b1, 5'd0, 1'b0, '0, 4'h0, 32'h0);
        repeat (Lat - 1) idle();
        total++;
        if ({dOutValid, dOut} !== {1'b1, 32'd5})
            $display("FAIL write_read: got v=%b d=%h want v=1 d=00000005", dOutValid, dOut);
        else passed++;
        idle();
        total++;
        if ({dOutValid, dOut} !== {1'b0, 32'd5})
            $display("FAIL read_hold: got v=%b d=%h want v=0 d=00000005", dOutValid, dOut);
        else passed++;
    endtask

    task automatic test_byte_enable();
        step(1'b0, '0, 1'b1, 5'd3, 4'hF, 32'hAABBCCDD);
        step(1'b0, '0, 1'b1, 5'd3, 4'b0101, 32'h11223344);
        step(1'b1, 5'd3, 1'b0, '0, 4'h0, 32'h0);
        repeat (Lat - 1) idle();
        total++;
        if ({dOutValid, dOut} !== {1'b1, 32'hAA22CC44})
            $display("FAIL byte_enable: got v=%b d=%h want v=1 d=aa22cc44", dOutValid, dOut);
        else passed++;
        step(1'b0, '0, 1'b1, 5'd3, 4'b0000, 32'hFFFFFFFF);
        step(1'b1, 5'd3, 1'b0, '0, 4'h0, 32'h0);
        repeat (Lat - 1) idle();
        total++;
        if (dOut !== 32'hAA22CC44) $display("FAIL byte_en_zero: got %h want aa22cc44", dOut);
        else passed++;
    endtask

    task automatic test_collision();
        step(1'b0, '0, 1'b1, 5'd7, 4'hF, 32'h01020304);
        step(1'b1, 5'd7, 1'b1, 5'd7, 4'b0011, 32'hDEADBEEF);
        repeat (Lat - 1) idle();
        total++;
        if ({dOutValid, dOut} !== {1'b1, 32'h0102BEEF})
            $display("FAIL collision: got v=%b d=%h want v=1 d=0102beef", dOutValid, dOut);
        else passed++;
        // Different addresses in the same cycle both complete.
        step(1'b1, 5'd3, 1'b1, 5'd9, 4'hF, 32'h0BADF00D);
        repeat (Lat - 1) idle();
        total++;
        if (dOut !== 32'hAA22CC44) $display("FAIL dual_port_read: got %h want aa22cc44", dOut);
        else passed++;
        step(1'b1, 5'd9, 1'b0, '0, 4'h0, 32'h0);
        repeat (Lat - 1) idle();
        total++;
        if (dOut !== 32'h0BADF00D) $display("FAIL dual_port_write: got %h want 0badf00d", dOut);
        else passed++;
    endtask

    task automatic test_out_of_range();
        step(1'b1, 5'd20, 1'b0, '0, 4'h0, 32'h0);
        repeat (Lat - 1) idle();
        total++;
        if ({dOutValid, addrError, dOut} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL oor_read: got v=%b e=%b d=%h want v=1 e=1 d=0", dOutValid, addrError,
                     dOut);
        else passed++;
        idle();
        total++;
        if (addrError !== 1'b0) $display("FAIL oor_pulse: got %b want 0", addrError);
        else passed++;
        step(1'b0, '0, 1'b1, 5'd20, 4'hF, 32'hFFFFFFFF);
        total++;
        if (got !== exp_vec) $display("FAIL oor_write: got %h want %h", got, exp_vec);
        else passed++;
        for (int a = 0; a < D + Lat; a++) begin
            if (a < D) step(1'b1, AW'(a), 1'b0, '0, 4'h0, 32'h0);
            else idle();
            total++;
            if (got !== exp_vec) $display("FAIL oor_scan[%0d]: got %h want %h", a, got, exp_vec);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 18)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 18)), 4'($urandom_range(0, 15)), $urandom);
            total++;
            if (got !== exp_vec) $display("FAIL random[%0d]: got %h want %h", i, got, exp_vec);
            else passed++;
        end
    endtask

    task automatic test_reset_restart();
        int cnt;
        apply_reset(2);
        repeat (5) idle();
        apply_reset(1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin idle(); cnt++; end
        total++;
        if (cnt != D) $display("FAIL restart_busy_len: got %0d want %0d", cnt, D);
        else passed++;
        step(1'b0, '0, 1'b1, 5'd2, 4'hF, 32'h5);
        apply_reset(2);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin idle(); cnt++; end
        total++;
        if (cnt != D) $display("FAIL rereset_busy_len: got %0d want %0d", cnt, D);
        else passed++;
        step(1'b1, 5'd2, 1'b0, '0, 4'h0, 32'h0);
        repeat (Lat - 1) idle();
        total++;
        if ({dOutValid, dOut} !== {1'b1, 32'h0})
            $display("FAIL reset_clears: got v=%b d=%h want v=1 d=0", dOutValid, dOut);
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_restart();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
